// File: rtl/l0_pkg.sv
`default_nettype none
// ============================================================================
// Package  : l0_pkg
// Brief    : Shared state encoding and sizing constants for the L0 sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package l0_pkg;

  localparam int L0_ROW   = 8;
  localparam int L0_DEPTH = 64;
  localparam int SRAM_AW  = 11;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_FILL_TAIL = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_FLUSH     = 3'd4,
    ST_DONE      = 3'd5
  } l0_seq_state_t;

endpackage
`default_nettype wire

// File: rtl/l0_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : l0_seq_ctrl_if
// Brief     : Job, SRAM and L0 signals of the sequencer. L0_SEQ_CTRL_PERF_EN
//             adds the perf counter outputs.
// Revision  : 1.0 - initial release
// ============================================================================
interface l0_seq_ctrl_if
  import l0_pkg::*;
#(
  parameter int AW = SRAM_AW,
  parameter int NW = 7
);
  logic          start;
  logic [AW-1:0] base_addr;
  logic [NW-1:0] num_vec;
  logic          row_mode;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_addr;
  logic          l0_wr;
  logic          l0_rd;
  logic          l0_mode;
  logic          l0_ready;
  logic          l0_full;
  logic          busy;
  logic          done;
  logic          err;
`ifdef L0_SEQ_CTRL_PERF_EN
  logic [15:0]   perf_cycles;
  logic [15:0]   perf_stalls;

  modport master (
    input  start, base_addr, num_vec, row_mode, l0_ready, l0_full,
    output sram_cen, sram_wen, sram_addr, l0_wr, l0_rd, l0_mode, busy, done, err,
    output perf_cycles, perf_stalls
  );
  modport slave (
    output start, base_addr, num_vec, row_mode, l0_ready, l0_full,
    input  sram_cen, sram_wen, sram_addr, l0_wr, l0_rd, l0_mode, busy, done, err,
    input  perf_cycles, perf_stalls
  );
`else
  modport master (
    input  start, base_addr, num_vec, row_mode, l0_ready, l0_full,
    output sram_cen, sram_wen, sram_addr, l0_wr, l0_rd, l0_mode, busy, done, err
  );
  modport slave (
    output start, base_addr, num_vec, row_mode, l0_ready, l0_full,
    input  sram_cen, sram_wen, sram_addr, l0_wr, l0_rd, l0_mode, busy, done, err
  );
`endif
endinterface
`default_nettype wire

// File: rtl/l0_seq_cnt.sv
`default_nettype none
// ============================================================================
// Module   : l0_seq_cnt
// Brief    : Loadable up-counter with a terminal-count compare.
// Revision : 1.0 - initial release
// ============================================================================
module l0_seq_cnt #(
  parameter int W = 7
) (
  input  wire          clk,
  input  wire          reset,
  input  wire          i_load,
  input  wire  [W-1:0] i_load_val,
  input  wire          i_en,
  input  wire  [W-1:0] i_term,
  output logic         o_tc
);
  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset)       r_count <= '0;
    else if (i_load) r_count <= i_load_val;
    else if (i_en)   r_count <= r_count + W'(1);
  end

  assign o_tc = (r_count == i_term);

endmodule
`default_nettype wire

// File: rtl/l0_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : l0_seq_ctrl
// Brief    : Fills L0 with N vectors from SRAM, then drains them into the array.
//            Define L0_SEQ_CTRL_PERF_EN for busy-cycle and stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module l0_seq_ctrl
  import l0_pkg::*;
#(
  parameter int ROW   = L0_ROW,
  parameter int DEPTH = L0_DEPTH,
  parameter int AW    = SRAM_AW,
  parameter int NW    = 7
) (
  input  wire           clk,
  input  wire           reset,
  l0_seq_ctrl_if.master bus
);
  localparam int              c_FW         = (ROW > 2) ? $clog2(ROW) : 1;
  localparam logic [c_FW-1:0] c_FLUSH_TERM = c_FW'((ROW >= 2) ? ROW - 2 : 0);
  localparam logic [NW-1:0]   c_DEPTH      = NW'(DEPTH);

  l0_seq_state_t r_state, w_next_state;
  logic [AW-1:0] r_base, r_sram_addr, w_sram_addr;
  logic [NW-1:0] r_num;
  logic          r_sram_cen, r_l0_wr, r_l0_rd, r_l0_mode, r_busy, r_done, r_err, r_any;
  logic          w_sram_cen, w_l0_wr, w_l0_rd, w_l0_mode, w_busy, w_done, w_err, w_any;
  logic          w_legal, w_accept, w_reject, w_issue;
  logic          w_issue_tc, w_drain_tc, w_flush_tc;
  logic [NW-1:0] w_num_m1;

  assign w_legal  = (bus.num_vec != '0) && (bus.num_vec <= c_DEPTH);
  assign w_accept = (r_state == ST_IDLE) && bus.start && w_legal;
  assign w_reject = (r_state == ST_IDLE) && bus.start && !w_legal;
  // The accepting cycle already issues the first read so it lands at t+1.
  assign w_issue  = bus.l0_ready && (w_accept || (r_state == ST_FILL));
  assign w_num_m1 = r_num - NW'(1);

  l0_seq_cnt #(.W(NW)) u_issue_cnt (
    .clk(clk), .reset(reset),
    .i_load(w_accept), .i_load_val({{(NW-1){1'b0}}, bus.l0_ready}),
    .i_en(w_issue), .i_term(w_num_m1), .o_tc(w_issue_tc)
  );

  l0_seq_cnt #(.W(NW)) u_drain_cnt (
    .clk(clk), .reset(reset),
    .i_load(r_state == ST_FILL_TAIL), .i_load_val('0),
    .i_en(r_state == ST_DRAIN), .i_term(w_num_m1), .o_tc(w_drain_tc)
  );

  l0_seq_cnt #(.W(c_FW)) u_flush_cnt (
    .clk(clk), .reset(reset),
    .i_load(r_state == ST_DRAIN), .i_load_val('0),
    .i_en(r_state == ST_FLUSH), .i_term(c_FLUSH_TERM), .o_tc(w_flush_tc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_base      <= '0;
      r_num       <= '0;
      r_sram_cen  <= 1'b1;
      r_sram_addr <= '0;
      r_l0_wr     <= 1'b0;
      r_l0_rd     <= 1'b0;
      r_l0_mode   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_any       <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      if (w_accept) begin
        r_base <= bus.base_addr;
        r_num  <= bus.num_vec;
      end
      r_sram_cen  <= w_sram_cen;
      r_sram_addr <= w_sram_addr;
      r_l0_wr     <= w_l0_wr;
      r_l0_rd     <= w_l0_rd;
      r_l0_mode   <= w_l0_mode;
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_err       <= w_err;
      r_any       <= w_any;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:
        if (w_accept)
          w_next_state = (bus.l0_ready && bus.num_vec == NW'(1)) ? ST_FILL_TAIL : ST_FILL;
      ST_FILL:      if (w_issue && w_issue_tc) w_next_state = ST_FILL_TAIL;
      ST_FILL_TAIL: w_next_state = ST_DRAIN;
      ST_DRAIN:
        if (w_drain_tc) w_next_state = (r_l0_mode || ROW < 2) ? ST_DONE : ST_FLUSH;
      ST_FLUSH:     if (w_flush_tc) w_next_state = ST_DONE;
      ST_DONE:      w_next_state = ST_IDLE;
      default:      w_next_state = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; l0_wr trails a read by one cycle.
  always_comb begin
    w_sram_cen  = 1'b1;
    w_sram_addr = r_sram_addr;
    w_l0_wr     = ~r_sram_cen;
    w_l0_rd     = (r_state == ST_DRAIN);
    w_l0_mode   = r_l0_mode;
    w_busy      = r_busy;
    w_done      = (r_state == ST_DONE) || w_reject;
    w_err       = r_err;
    w_any       = r_any;
    if (w_accept) begin
      w_busy    = 1'b1;
      w_l0_mode = bus.row_mode;
      w_err     = 1'b0;
      w_any     = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_busy    = 1'b0;
    end
    if (w_issue) begin
      w_sram_cen = 1'b0;
      w_any      = 1'b1;
      if (w_accept)   w_sram_addr = bus.base_addr;
      else if (r_any) w_sram_addr = r_sram_addr + AW'(1);
      else            w_sram_addr = r_base;
    end
    if (w_reject || (r_l0_wr && bus.l0_full)) w_err = 1'b1;
  end

  assign bus.sram_cen  = r_sram_cen;
  assign bus.sram_wen  = 1'b1;
  assign bus.sram_addr = r_sram_addr;
  assign bus.l0_wr     = r_l0_wr;
  assign bus.l0_rd     = r_l0_rd;
  assign bus.l0_mode   = r_l0_mode;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.err       = r_err;

`ifdef L0_SEQ_CTRL_PERF_EN
  logic [15:0] r_perf_cycles, r_perf_stalls;

  always_ff @(posedge clk) begin
    if (reset || w_accept) begin
      r_perf_cycles <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (r_busy && r_perf_cycles != 16'hFFFF)
        r_perf_cycles <= r_perf_cycles + 16'd1;
      if (r_state == ST_FILL && !bus.l0_ready && r_perf_stalls != 16'hFFFF)
        r_perf_stalls <= r_perf_stalls + 16'd1;
    end
  end

  assign bus.perf_cycles = r_perf_cycles;
  assign bus.perf_stalls = r_perf_stalls;
`endif

endmodule
`default_nettype wire

// File: doc/l0_seq_ctrl.md
Name: l0_seq_ctrl

Overview:
- Sequencer for the 8-row L0 input buffer of the systolic array.
- Per job, it reads N activation vectors from the activation SRAM, then streams them out of L0 into the array.
- It drives the L0 rd, wr and read-mode inputs, and issues the SRAM read strobes and addresses.
- It sits between the top-level job controller (start/done) and the SRAM/L0 pair; the SRAM output feeds L0 input directly.

Parameters:
- ROW, 8: L0 row count; sets the stagger flush length.
- DEPTH, 64: per-row L0 FIFO depth; upper bound on N.
- AW, 11: SRAM address width.
- NW, 7: width of the num_vec input; must hold DEPTH.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle job request; sampled only in IDLE
- base_addr  in  AW  first SRAM address of the job
- num_vec  in  NW  vectors to load and stream (N)
- row_mode  in  1  1 = all rows read together; 0 = staggered, one row per cycle
- sram_cen  out  1  SRAM chip enable, active-low
- sram_wen  out  1  SRAM write enable, active-low; held 1 (read only)
- sram_addr  out  AW  SRAM read address
- l0_wr  out  1  L0 write strobe
- l0_rd  out  1  L0 read strobe
- l0_mode  out  1  L0 all-rows-at-a-time select
- l0_ready  in  1  L0 has room in every row
- l0_full  in  1  some L0 row is full
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job end
- err  out  1  sticky illegal-job or overflow flag; cleared by reset or the next accepted start

Behaviour:
- Reset values: sram_cen=1, sram_wen=1, sram_addr=0, l0_wr=0, l0_rd=0, l0_mode=0, busy=0, done=0, err=0; FSM in IDLE. Reset mid-job aborts the job immediately; L0 contents are not this block's concern.
- All outputs are registered.
- FSM states: IDLE, FILL, FILL_TAIL, DRAIN, FLUSH, DONE.
- IDLE:
  - start with 1<=num_vec<=DEPTH: latch base_addr, num_vec and row_mode (row_mode drives l0_mode for the whole job), clear err, busy=1, go to FILL.
  - start with num_vec=0 or num_vec>DEPTH: set err=1, pulse done the next cycle, go nowhere (stay IDLE).
- FILL:
  - Each cycle with l0_ready=1 and issued<N: sram_cen=0, sram_addr=base+issued, issued++.
  - l0_ready=0: hold (sram_cen=1, address unchanged).
  - SRAM read latency is 1 cycle, so l0_wr is the previous cycle's ~sram_cen, delayed one flop.
  - When the N-th read issues, go to FILL_TAIL.
- FILL_TAIL: one cycle so the final l0_wr completes. sram_cen=1. Go to DRAIN.
- DRAIN:
  - l0_rd=1 for exactly N consecutive cycles, then go to FLUSH.
  - L0 rows are never empty here because N vectors are resident.
- FLUSH:
  - row_mode=0: wait ROW-1 cycles so the last stagger-shifted row read completes.
  - row_mode=1: 0 cycles, pass straight through.
  - Then go to DONE.
- DONE: done=1 for one cycle, busy=0 on the following cycle, return to IDLE.
- start outside IDLE is ignored.
- l0_full=1 at any l0_wr: set err; the job continues.
- Address wraps modulo 2^AW.
- Latency for an unstalled job: start accepted at cycle t; first sram_cen=0 at t+1; last l0_wr at t+N+1; l0_rd high t+N+2 .. t+2N+1; done at t+2N+2 (all-row) or t+2N+ROW+1 (staggered).

Optional Feature:
- Macro: L0_SEQ_CTRL_PERF_EN.
- Defined: adds output perf_cycles[15:0] and output perf_stalls[15:0].
  - perf_cycles counts cycles with busy=1 in the last job; it saturates.
  - perf_stalls counts FILL cycles with l0_ready=0; it saturates.
  - Both clear on an accepted start and hold after done.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package l0_pkg:
  - FSM state enum l0_seq_state_t.
  - Constants L0_ROW=8 and L0_DEPTH=64.
  - SRAM_AW=11.
- One natural sub-module: l0_seq_cnt, a loadable up-counter with terminal-count flag.
  - Instantiated for the issue count, the drain count and the flush count.

Test Plan:
- base_addr=0x010, num_vec=4, row_mode=1, l0_ready=1:
  - sram_addr 0x010..0x013 on cycles t+1..t+4.
  - l0_wr t+2..t+5.
  - l0_rd t+6..t+9.
  - done at t+10; err=0.
- Same job with row_mode=0: l0_mode=0, l0_rd same window, done at t+17 (7-cycle flush).
- num_vec=8, l0_ready forced 0 for cycles t+3..t+5:
  - sram_cen high and address frozen during the stall.
  - All 8 addresses issued once.
  - perf_stalls=3 with PERF_EN defined.
- num_vec=0, then num_vec=65: err=1, done pulses, no sram_cen/l0_wr/l0_rd activity; next legal start clears err.
- num_vec=64, base_addr=0x7F0: address wraps 0x7FF→0x000; 64 writes and 64 reads occur.
- Reset asserted during DRAIN: next cycle l0_rd=0, busy=0, FSM in IDLE, no done pulse.
